// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
//
// Purpose: controller state type, register-index constants and the load-use
//          hazard predicate shared by pipe_hazard_ctrl.
// Ports:   none (package).

package pipe_ctrl_pkg;

    localparam int              REG_IDX_W = 5;
    localparam logic [4:0]      REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    // x0 is hardwired to zero, so a load "writing" it can never feed ID.
    function automatic logic load_use_hazard(
        input logic                 ex_mem_read,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic                 use_rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 use_rs2
    );
        return ex_mem_read && (ex_rd != REG_ZERO) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Purpose: counts cycles with inc=1, sticks at all-ones, cleared only by reset.
// Ports:   clk, rst_n (async active-low), inc (count this cycle), q (count).

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline enable/flush controller
//
// Purpose: drives PC, IF/ID, ID/EX and downstream pipeline enables/flushes from
//          startup priming, EX-resolved jumps, load-use hazards and data-memory
//          busy; keeps saturating stall/flush counters and a sticky busy-timeout.
// Ports:   clk, rst_n                         clock, async active-low reset
//          id_rs1/id_rs2/id_use_rs1/id_use_rs2 ID source operands
//          ex_rd, ex_mem_read                  EX destination / load flag
//          jump_i, mem_busy_i                  redirect / memory stall requests
//          pc_en, ifid_en, ifid_flush, idex_flush, pipe_en  pipeline controls
//          stall_cnt, flush_cnt, err_timeout   debug counters and error flag

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STARTUP_CYCLES = 2,
    parameter int BUSY_TIMEOUT   = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 jump_i,
    input  logic                 mem_busy_i,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 pipe_en,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 err_timeout
);

    localparam logic [7:0]  START_LAST = 8'(STARTUP_CYCLES - 1);
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TIMEOUT);

    ctrl_state_t r_state;
    logic [7:0]  r_start_cnt;
    logic [15:0] r_busy_cnt;
    logic        r_err;

    ctrl_state_t w_state_nxt;
    logic [7:0]  w_start_nxt;
    logic [15:0] w_busy_nxt;
    logic        w_stall_inc;
    logic        w_flush_inc;
    logic        w_err_set;
    logic        w_hazard;

    assign w_hazard = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_use_rs1,
                                      id_rs2, id_use_rs2);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_en     = 1'b1;
        w_state_nxt = r_state;
        w_start_nxt = r_start_cnt;
        w_busy_nxt  = r_busy_cnt;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        w_err_set   = 1'b0;

        case (r_state)
            START: begin
                // Instruction memory is priming: keep bubbles flowing, PC parked.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (r_start_cnt == START_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_start_nxt = r_start_cnt + 8'd1;
                end
            end

            RUN: begin
                if (mem_busy_i) begin
                    // Freeze right away; a concurrent jump stays held in EX.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    pipe_en     = 1'b0;
                    w_state_nxt = MEM_WAIT;
                    w_busy_nxt  = 16'd1;
                    w_stall_inc = 1'b1;
                end else if (jump_i) begin
                    // ID holds a wrong-path instruction, so any hazard is moot.
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_hazard) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_flush  = 1'b1;
                    w_stall_inc = 1'b1;
                end
            end

            MEM_WAIT: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                pipe_en     = 1'b0;
                w_stall_inc = 1'b1;
                if (!mem_busy_i) begin
                    w_state_nxt = RUN;
                end else if (r_busy_cnt == BUSY_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_busy_nxt = r_busy_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= START;
            r_start_cnt <= 8'd0;
            r_busy_cnt  <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_cnt <= w_start_nxt;
            r_busy_cnt  <= w_busy_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    localparam int SC  = 2;
    localparam int BT  = 4;
    localparam int CW  = 3;
    localparam int SAT = 7;

    logic          clk;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, jump_i, mem_busy_i;
    logic          pc_en, ifid_en, ifid_flush, idex_flush, pipe_en;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          err_timeout;
    logic [4:0]    outs;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: remaining startup cycles, waiting flag, busy run length.
    int m_left, m_run, m_stall, m_flush;
    bit m_wait, m_err;

    pipe_hazard_ctrl #(
        .STARTUP_CYCLES (SC),
        .BUSY_TIMEOUT   (BT),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .jump_i      (jump_i),
        .mem_busy_i  (mem_busy_i),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .pipe_en     (pipe_en),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .err_timeout (err_timeout)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_hazard();
        return ex_mem_read && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en}
    function automatic logic [4:0] m_outs();
        if (m_left > 0)      return 5'b00111;
        if (m_wait)          return 5'b00000;
        if (mem_busy_i)      return 5'b00000;
        if (jump_i)          return 5'b11111;
        if (m_hazard())      return 5'b00011;
        return 5'b11001;
    endfunction

    function automatic int sat(input int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    task automatic model_reset();
        m_left = SC; m_wait = 0; m_run = 0;
        m_stall = 0; m_flush = 0; m_err = 0;
    endtask

    task automatic model_step();
        if (m_left > 0) begin
            m_left--;
        end else if (m_wait) begin
            m_stall = sat(m_stall);
            if (!mem_busy_i) m_wait = 0;
            else if (m_run == BT) begin m_err = 1; m_wait = 0; end
            else m_run++;
        end else if (mem_busy_i) begin
            m_stall = sat(m_stall); m_wait = 1; m_run = 1;
        end else if (jump_i) begin
            m_flush = sat(m_flush);
        end else if (m_hazard()) begin
            m_stall = sat(m_stall);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; jump_i = 0; mem_busy_i = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        id_rs1 = 3; id_use_rs1 = 1;
    endtask

    // Returns at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic start_run();
        do_reset();
        repeat (SC) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        #1;
        checks++;
        if (outs !== 5'b00111) begin
            failures++;
            $display("FAIL reset_outs: got %b expected %b", outs, 5'b00111);
        end
        checks++;
        if ({stall_cnt, flush_cnt, err_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_cnt: stall=%0d flush=%0d err=%0b expected 0", stall_cnt, flush_cnt, err_timeout);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < SC; i++) begin
            #1;
            checks++;
            if ({pc_en, ifid_flush} !== 2'b01) begin
                failures++;
                $display("FAIL startup_hold_%0d: pc_en/ifid_flush got %b expected 01", i, {pc_en, ifid_flush});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({pc_en, ifid_flush} !== 2'b10) begin
            failures++;
            $display("FAIL startup_done: pc_en/ifid_flush got %b expected 10", {pc_en, ifid_flush});
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            failures++;
            $display("FAIL startup_cnt: stall=%0d flush=%0d expected 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        start_run();
        set_load_use();
        #1;
        checks++;
        if (outs !== 5'b00011) begin
            failures++;
            $display("FAIL load_use_outs: got %b expected 00011", outs);
        end
        @(negedge clk);
        ex_mem_read = 0;
        #1;
        checks++;
        if (outs !== 5'b11001 || stall_cnt !== 3'd1) begin
            failures++;
            $display("FAIL load_use_after: outs=%b stall=%0d expected 11001 stall=1", outs, stall_cnt);
        end
        @(negedge clk);
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0;
        #1;
        checks++;
        if (outs !== 5'b11001) begin
            failures++;
            $display("FAIL load_use_x0: got %b expected 11001", outs);
        end
        @(negedge clk);
        ex_rd = 3; id_rs1 = 3; id_use_rs1 = 0; id_rs2 = 7;
        #1;
        checks++;
        if (outs !== 5'b11001) begin
            failures++;
            $display("FAIL load_use_unused_rs1: got %b expected 11001", outs);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (stall_cnt !== 3'd1) begin
            failures++;
            $display("FAIL load_use_cnt: stall=%0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_jump_hazard();
        start_run();
        set_load_use();
        jump_i = 1;
        #1;
        checks++;
        if (outs !== 5'b11111) begin
            failures++;
            $display("FAIL jump_outs: got %b expected 11111", outs);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (flush_cnt !== 3'd1 || stall_cnt !== 3'd0) begin
            failures++;
            $display("FAIL jump_cnt: flush=%0d stall=%0d expected flush=1 stall=0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_busy_jump();
        start_run();
        jump_i = 1;
        for (int i = 0; i < 4; i++) begin
            mem_busy_i = (i < 3);
            #1;
            checks++;
            if (outs !== 5'b00000) begin
                failures++;
                $display("FAIL busy_freeze_%0d: got %b expected 00000", i, outs);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (outs !== 5'b11111 || stall_cnt !== 3'd4) begin
            failures++;
            $display("FAIL busy_jump_resume: outs=%b stall=%0d expected 11111 stall=4", outs, stall_cnt);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (flush_cnt !== 3'd1) begin
            failures++;
            $display("FAIL busy_jump_flush: flush=%0d expected 1", flush_cnt);
        end
    endtask

    task automatic test_timeout();
        start_run();
        mem_busy_i = 1;
        for (int i = 0; i <= BT; i++) begin
            #1;
            checks++;
            if (err_timeout !== 1'b0) begin
                failures++;
                $display("FAIL timeout_early_%0d: err=%0b expected 0", i, err_timeout);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (err_timeout !== 1'b1 || outs !== 5'b00000) begin
            failures++;
            $display("FAIL timeout_set: err=%0b outs=%b expected err=1 outs=00000", err_timeout, outs);
        end
        mem_busy_i = 0;
        #1;
        checks++;
        if (outs !== 5'b11001) begin
            failures++;
            $display("FAIL timeout_run: got %b expected 11001", outs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: err=%0b expected 1", err_timeout);
        end
        mem_busy_i = 1;
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (err_timeout !== 1'b0 || outs !== 5'b00111) begin
            failures++;
            $display("FAIL timeout_async_rst: err=%0b outs=%b expected err=0 outs=00111", err_timeout, outs);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
    endtask

    task automatic test_saturation();
        start_run();
        for (int i = 0; i < 10; i++) begin
            set_load_use();
            @(negedge clk);
            ex_mem_read = 0;
            @(negedge clk);
            if (i == 5) begin
                #1;
                checks++;
                if (stall_cnt !== 3'd6) begin
                    failures++;
                    $display("FAIL sat_mid: stall=%0d expected 6", stall_cnt);
                end
            end
        end
        #1;
        checks++;
        if (stall_cnt !== 3'd7) begin
            failures++;
            $display("FAIL sat_final: stall=%0d expected 7", stall_cnt);
        end
    endtask

    task automatic test_random();
        bit busy_prev = 0;
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 0;
                #1;
                model_reset();
                checks++;
                if (outs !== 5'b00111 || {stall_cnt, flush_cnt, err_timeout} !== '0) begin
                    failures++;
                    $display("FAIL rand_rst_%0d: outs=%b stall=%0d flush=%0d err=%0b", n, outs, stall_cnt, flush_cnt, err_timeout);
                end
                @(negedge clk);
                rst_n = 1;
                continue;
            end
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            jump_i      = ($urandom_range(0, 4) == 0);
            mem_busy_i  = busy_prev ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            busy_prev   = mem_busy_i;
            #1;
            checks++;
            if (outs !== m_outs()) begin
                failures++;
                $display("FAIL rand_outs_%0d: got %b expected %b", n, outs, m_outs());
            end
            checks++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || err_timeout !== m_err) begin
                failures++;
                $display("FAIL rand_state_%0d: stall=%0d/%0d flush=%0d/%0d err=%0b/%0b (got/expected)",
                         n, stall_cnt, m_stall, flush_cnt, m_flush, err_timeout, m_err);
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_load_use();
        test_jump_hazard();
        test_busy_jump();
        test_timeout();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 5-stage core. It generates enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers from load-use hazards, taken jumps/branches resolved in EX, and a multicycle data-memory busy signal. It holds the front end quiet after reset while instruction memory primes, and keeps saturating stall/flush event counters for debug. It sits beside the pipeline registers; its `ifid_flush` drives the IF/ID register's flush input.

## Interface
- `STARTUP_CYCLES`, default 2: cycles the front end is held after reset release. Legal range 1..255.
- `BUSY_TIMEOUT`, default 64: maximum consecutive `mem_busy_i` cycles before the timeout error is flagged. Legal range 2..65535.
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `id_rs1`, `id_rs2` in 5: source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `ex_rd` in 5: destination index of the instruction in EX.
- `ex_mem_read` in 1: the EX instruction is a load.
- `jump_i` in 1: jump or taken branch resolved in EX this cycle.
- `mem_busy_i` in 1: the data memory/IO cannot complete the MEM-stage access this cycle.
- `pc_en` out 1: PC register load enable.
- `ifid_en` out 1: IF/ID capture enable.
- `ifid_flush` out 1: IF/ID clear-to-bubble.
- `idex_flush` out 1: ID/EX clear-to-bubble.
- `pipe_en` out 1: ID/EX, EX/MEM and MEM/WB capture enable.
- `stall_cnt` out CNT_W: saturating count of stall cycles.
- `flush_cnt` out CNT_W: saturating count of jump flush events.
- `err_timeout` out 1: sticky; set on busy timeout.

## Operation
- The FSM has three states: START, RUN and MEM_WAIT. Reset enters START with the startup counter at 0.
- **START:** `pc_en`=0, `ifid_en`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=1. The counter increments each cycle. When it reaches STARTUP_CYCLES-1, the next state is RUN. All other inputs are ignored.
- **RUN, priority 1 (busy):** `mem_busy_i`=1. Next state is MEM_WAIT; the busy counter loads 1. This cycle already freezes: `pc_en`=`ifid_en`=`pipe_en`=0 and no flushes. A pending `jump_i` is not lost, because EX is held and re-presents it.
- **RUN, priority 2 (jump):** `jump_i`=1. `pc_en`=1 (PC loads the target), `ifid_en`=1, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=1. `flush_cnt` increments. A load-use hazard in the same cycle is overridden, because the ID instruction is wrong-path.
- **RUN, priority 3 (load-use):** The hazard is `ex_mem_read` && `ex_rd`≠0 && ((`id_use_rs1` && `id_rs1`==`ex_rd`) || (`id_use_rs2` && `id_rs2`==`ex_rd`)). On a hazard: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `pipe_en`=1. This lasts exactly one cycle, with no state change. `stall_cnt` increments.
- **RUN, otherwise:** all enables are 1 and all flushes are 0.
- **MEM_WAIT:** all enables are 0 and no flushes. `stall_cnt` increments every cycle in this state.
  - If `mem_busy_i`=0, return to RUN. The returning cycle's outputs are the MEM_WAIT freeze outputs; normal RUN decoding resumes on the next cycle.
  - If `mem_busy_i` is still 1 and the busy counter equals BUSY_TIMEOUT, set `err_timeout` and force a return to RUN. Outputs in RUN then follow the rules above.
- **Counters:** both saturate at 2^CNT_W-1 and never wrap. Only reset clears them. A busy-entry cycle in RUN also increments `stall_cnt`.
- **Register 0:** `ex_rd`=0 never causes a stall.

## Timing
- All outputs are combinational from the registered state plus current inputs, and are valid in the same cycle.
- Counters, state and `err_timeout` update on the rising edge after the qualifying cycle.
- **Reset values (while `rst_n`=0):**
  - state START, startup counter 0, busy counter 0;
  - `pc_en`=0, `ifid_en`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=1;
  - `stall_cnt`=0, `flush_cnt`=0, `err_timeout`=0.
- **Reset asserted mid-operation** (any state, including MEM_WAIT) takes effect immediately and asynchronously. Release is synchronous to `clk`, with the first START cycle after release.
- **Load-use latency:** a one-cycle bubble. The dependent instruction leaves ID one cycle later than without the hazard.
- **Jump penalty:** two squashed instructions (IF/ID and ID/EX).

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the `ctrl_state_t` enum (START, RUN, MEM_WAIT);
  - `REG_IDX_W`=5;
  - `REG_ZERO`=5'd0.
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst_n`, `inc`, `q`) is instantiated twice, once for `stall_cnt` and once for `flush_cnt`.

## Test plan
- **Reset with STARTUP_CYCLES=2:** release reset → `pc_en`=0 and `ifid_flush`=1 for exactly 2 cycles, then `pc_en`=1 and `ifid_flush`=0. All counters are 0.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1, and `stall_cnt` reads 1. Repeating with `ex_rd`=0 → no stall.
- **Jump together with the load-use pattern:** `jump_i`=1 in the same cycle → `ifid_flush`=1, `idex_flush`=1, `pc_en`=1, `flush_cnt`=1, `stall_cnt` unchanged.
- **Busy during a jump:** `mem_busy_i`=1 for 3 cycles while `jump_i`=1 → freeze (all enables 0) for 4 cycles. The jump flush then occurs on the next cycle, and `stall_cnt`=4.
- **Timeout with BUSY_TIMEOUT=4:** `mem_busy_i` held high → `err_timeout` rises after the 4th MEM_WAIT cycle and stays set after busy drops. Asserting `rst_n`=0 mid-wait clears it at once.
- **Saturation with CNT_W=3:** 10 load-use stalls → `stall_cnt`=7.
